// File: rtl/r8_frame_sequencer_if.sv
// Pixel-stream and status bundle between the pixel source/R8 controller and the frame sequencer.
interface r8_frame_sequencer_if #(
  parameter int CNT_W = 10
);
  logic             start_i;
  logic             abort_i;
  logic             pix_valid_i;
  logic [CNT_W-1:0] col_cnt_o;
  logic [CNT_W-1:0] row_cnt_o;
  logic             start_gt_o;
  logic             row_eq_max_o;
  logic             row_start_o;
  logic             frame_done_o;
  logic             busy_o;
  logic             ovf_o;

  modport master (
    output start_i, abort_i, pix_valid_i,
    input  col_cnt_o, row_cnt_o, start_gt_o, row_eq_max_o,
           row_start_o, frame_done_o, busy_o, ovf_o
  );

  modport slave (
    input  start_i, abort_i, pix_valid_i,
    output col_cnt_o, row_cnt_o, start_gt_o, row_eq_max_o,
           row_start_o, frame_done_o, busy_o, ovf_o
  );
endinterface

// File: rtl/r8_frame_sequencer.sv
// Frame-level sequencer for the R8 windowed filter: tracks pixel position and runs
// warm-up, active and flush phases, producing registered flags and strobes.
module r8_frame_sequencer #(
  parameter int COLS        = 19,
  parameter int ROWS        = 19,
  parameter int WARMUP_ROWS = 3,
  parameter int FLUSH_CYC   = 19,
  parameter int CNT_W       = 10
) (
  input logic             clk,
  input logic             rst_n,
  r8_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WARMUP, ACTIVE, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_ROWS - 1);
  // FLUSH covers the last-pixel cycle plus FLUSH_CYC drain cycles, so DONE
  // lands FLUSH_CYC+1 edges after the last accepted pixel.
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(FLUSH_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             start_gt_q, start_gt_d;
  logic             row_eq_max_q, row_eq_max_d;
  logic             row_start_q, row_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      flush_q      <= '0;
      start_gt_q   <= 1'b0;
      row_eq_max_q <= 1'b0;
      row_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_q      <= flush_d;
      start_gt_q   <= start_gt_d;
      row_eq_max_q <= row_eq_max_d;
      row_start_q  <= row_start_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  assign last_col = (col_q == COL_LAST);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_d      = flush_q;
    start_gt_d   = start_gt_q;
    row_eq_max_d = row_eq_max_q;
    row_start_d  = 1'b0;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = WARMUP;
          ovf_d   = 1'b0;
        end
      end
      WARMUP: begin
        if (bus.pix_valid_i) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == WARM_LAST) begin
              state_d    = ACTIVE;
              start_gt_d = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.pix_valid_i) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              state_d      = FLUSH;
              row_eq_max_d = 1'b1;
              flush_d      = '0;
            end else begin
              row_start_d = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (bus.pix_valid_i) ovf_d = 1'b1;
        if (flush_q == FLUSH_END) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.pix_valid_i) ovf_d = 1'b1;
        state_d      = IDLE;
        col_d        = '0;
        row_d        = '0;
        flush_d      = '0;
        start_gt_d   = 1'b0;
        row_eq_max_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (bus.abort_i) begin
      state_d      = IDLE;
      col_d        = '0;
      row_d        = '0;
      flush_d      = '0;
      start_gt_d   = 1'b0;
      row_eq_max_d = 1'b0;
      row_start_d  = 1'b0;
      frame_done_d = 1'b0;
      ovf_d        = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.col_cnt_o    = col_q;
  assign bus.row_cnt_o    = row_q;
  assign bus.start_gt_o   = start_gt_q;
  assign bus.row_eq_max_o = row_eq_max_q;
  assign bus.row_start_o  = row_start_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.busy_o       = busy_q;
  assign bus.ovf_o        = ovf_q;

endmodule
